// File: rtl/sysid_arb_pkg.sv
// Shared constants for the system-ID read arbiter.
// Address map of the sysid slave and counter sizing.
package sysid_arb_pkg;

  localparam logic SYSID_ADDR_ID        = 1'b0;
  localparam logic SYSID_ADDR_TIMESTAMP = 1'b1;
  localparam int   NUM_MASTERS_MAX      = 8;
  localparam int   BUSY_CNT_W           = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority encoder: first requester at or after ptr wins.
// Produces a one-hot grant plus its index.
module rr_arbiter
  import sysid_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          grant_vld
);

  always_comb begin : scan
    int j;
    logic [PW-1:0] jj;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    j         = 0;
    jj        = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      jj = PW'(j);
      if (!grant_vld && req[jj]) begin
        grant[jj] = 1'b1;
        grant_idx = jj;
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sysid_read_arbiter.sv
// Round-robin share of the sysid slave among several read masters.
// One read per cycle; response registered with a one-cycle strobe.
module sysid_read_arbiter
  import sysid_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int DATA_W      = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_MASTERS-1:0] m_read,
  input  logic [NUM_MASTERS-1:0] m_address,
  output logic [NUM_MASTERS-1:0] m_waitrequest,
  output logic [NUM_MASTERS-1:0] m_readdatavalid,
  output logic [DATA_W-1:0]     m_readdata,
  output logic                  s_address,
  input  logic [DATA_W-1:0]     s_readdata,
  output logic [BUSY_CNT_W-1:0] busy_cycles
);

  localparam int PW = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] grant;
  logic [PW-1:0]          gidx;
  logic                   gvld;
  logic                   multi;

  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [NUM_MASTERS-1:0] rvalid_q, rvalid_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic [BUSY_CNT_W-1:0]  busy_q, busy_d;

  // No grant while in reset, so waitrequest simply mirrors m_read.
  assign req = m_read & {NUM_MASTERS{reset_n}};

  rr_arbiter #(
    .N  (NUM_MASTERS),
    .PW (PW)
  ) u_rr (
    .req       (req),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (gidx),
    .grant_vld (gvld)
  );

  assign m_waitrequest   = m_read & ~grant;
  assign s_address       = gvld ? m_address[gidx] : SYSID_ADDR_ID;
  assign m_readdatavalid = rvalid_q;
  assign m_readdata      = rdata_q;
  assign busy_cycles     = busy_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gvld) begin
      rr_ptr_d = (gidx == PW'(NUM_MASTERS - 1)) ? '0 : gidx + PW'(1);
    end
    rvalid_d = grant;
    rdata_d  = gvld ? s_readdata : rdata_q;
    multi    = |(m_read & (m_read - NUM_MASTERS'(1)));
    busy_d   = busy_q;
    if (multi && busy_q != '1) begin
      busy_d = busy_q + BUSY_CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      busy_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_sysid_read_arbiter.sv
// Bench for sysid_read_arbiter with a stub sysid slave.
// Expected responses are queued at accept and popped on readdatavalid.
module tb_sysid_read_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [2:0]  m_read;
  logic [2:0]  m_address;
  logic [2:0]  m_waitrequest;
  logic [2:0]  m_readdatavalid;
  logic [31:0] m_readdata;
  logic        s_address;
  logic [31:0] s_readdata;
  logic [15:0] busy_cycles;

  typedef struct {
    logic [2:0]  v;
    logic [31:0] d;
  } exp_t;

  exp_t        sb[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          exp_busy = 0;
  logic [31:0] last_d = '0;

  always #5 clock = ~clock;

  assign s_readdata = s_address ? 32'h5923_F616 : 32'h0000_0000;

  sysid_read_arbiter #(
    .NUM_MASTERS (3),
    .DATA_W      (32)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .m_read          (m_read),
    .m_address       (m_address),
    .m_waitrequest   (m_waitrequest),
    .m_readdatavalid (m_readdatavalid),
    .m_readdata      (m_readdata),
    .s_address       (s_address),
    .s_readdata      (s_readdata),
    .busy_cycles     (busy_cycles)
  );

  function automatic logic [31:0] exp_data(input logic a);
    return a ? 32'h5923_F616 : 32'h0000_0000;
  endfunction

  function automatic exp_t mk_exp(input logic [2:0] g, input logic [2:0] ad);
    exp_t e;
    e.v = g;
    e.d = '0;
    for (int i = 0; i < 3; i++) if (g[i]) e.d = exp_data(ad[i]);
    return e;
  endfunction

  task automatic test_reset();
    exp_t e;
    reset_n = 1'b0;
    m_read = 3'b111;
    m_address = 3'b000;
    #1;
    repeat (2) @(posedge clock);
    #1;
    total_cnt++;
    if (m_readdatavalid !== 3'b000)
      $display("FAIL rst_valid got=%b exp=000", m_readdatavalid);
    else pass_cnt++;
    total_cnt++;
    if (m_waitrequest !== 3'b111)
      $display("FAIL rst_wait got=%b exp=111", m_waitrequest);
    else pass_cnt++;
    total_cnt++;
    if (busy_cycles !== 16'd0 || m_readdata !== 32'd0)
      $display("FAIL rst_regs busy=%0d data=%h exp=0", busy_cycles, m_readdata);
    else pass_cnt++;
    reset_n = 1'b1;
    exp_busy = 1;
    #1;
    total_cnt++;
    if (m_waitrequest !== 3'b110)
      $display("FAIL rst_first_grant got=%b exp=110", m_waitrequest);
    else pass_cnt++;
    sb.push_back(mk_exp(3'b001, m_address));
    @(posedge clock);
    #1;
    m_read = 3'b000;
    e = sb.pop_front();
    total_cnt++;
    if (m_readdatavalid !== e.v || m_readdata !== e.d)
      $display("FAIL rst_resp got=%b/%h exp=%b/%h", m_readdatavalid, m_readdata, e.v, e.d);
    else pass_cnt++;
    last_d = e.d;
  endtask

  task automatic test_single_read();
    logic [2:0] rd [5] = '{3'b001, 3'b000, 3'b001, 3'b001, 3'b000};
    logic [2:0] wt [5] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    logic [2:0] ad [5] = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b000};
    exp_t e;
    for (int s = 0; s < 5; s++) begin
      m_read = rd[s];
      m_address = ad[s];
      if ($countones(rd[s]) >= 2) exp_busy++;
      #1;
      total_cnt++;
      if (m_waitrequest !== wt[s])
        $display("FAIL single_wait s=%0d got=%b exp=%b", s, m_waitrequest, wt[s]);
      else pass_cnt++;
      if ((rd[s] & ~wt[s]) != 3'b000) sb.push_back(mk_exp(rd[s] & ~wt[s], ad[s]));
      @(posedge clock);
      #1;
      total_cnt++;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (m_readdatavalid !== e.v || m_readdata !== e.d)
          $display("FAIL single_resp s=%0d got=%b/%h exp=%b/%h", s, m_readdatavalid, m_readdata, e.v, e.d);
        else pass_cnt++;
        last_d = e.d;
      end else begin
        if (m_readdatavalid !== 3'b000 || m_readdata !== last_d)
          $display("FAIL single_idle s=%0d got=%b/%h exp=000/%h", s, m_readdatavalid, m_readdata, last_d);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_contention();
    logic [2:0] rd [5] = '{3'b100, 3'b111, 3'b110, 3'b100, 3'b000};
    logic [2:0] wt [5] = '{3'b000, 3'b110, 3'b100, 3'b000, 3'b000};
    exp_t e;
    m_address = 3'b101;
    for (int s = 0; s < 5; s++) begin
      m_read = rd[s];
      if ($countones(rd[s]) >= 2) exp_busy++;
      #1;
      total_cnt++;
      if (m_waitrequest !== wt[s])
        $display("FAIL cont_wait s=%0d got=%b exp=%b", s, m_waitrequest, wt[s]);
      else pass_cnt++;
      if ((rd[s] & ~wt[s]) != 3'b000) sb.push_back(mk_exp(rd[s] & ~wt[s], m_address));
      @(posedge clock);
      #1;
      total_cnt++;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (m_readdatavalid !== e.v || m_readdata !== e.d)
          $display("FAIL cont_resp s=%0d got=%b/%h exp=%b/%h", s, m_readdatavalid, m_readdata, e.v, e.d);
        else pass_cnt++;
        last_d = e.d;
      end else begin
        if (m_readdatavalid !== 3'b000 || m_readdata !== last_d)
          $display("FAIL cont_idle s=%0d got=%b/%h exp=000/%h", s, m_readdatavalid, m_readdata, last_d);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (busy_cycles !== 16'(exp_busy))
      $display("FAIL cont_busy got=%0d exp=%0d", busy_cycles, exp_busy);
    else pass_cnt++;
  endtask

  task automatic test_rotation();
    logic [2:0] rd [4] = '{3'b010, 3'b101, 3'b001, 3'b000};
    logic [2:0] wt [4] = '{3'b000, 3'b001, 3'b000, 3'b000};
    exp_t e;
    m_address = 3'b010;
    for (int s = 0; s < 4; s++) begin
      m_read = rd[s];
      if ($countones(rd[s]) >= 2) exp_busy++;
      #1;
      total_cnt++;
      if (m_waitrequest !== wt[s])
        $display("FAIL rot_wait s=%0d got=%b exp=%b", s, m_waitrequest, wt[s]);
      else pass_cnt++;
      if ((rd[s] & ~wt[s]) != 3'b000) sb.push_back(mk_exp(rd[s] & ~wt[s], m_address));
      @(posedge clock);
      #1;
      total_cnt++;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (m_readdatavalid !== e.v || m_readdata !== e.d)
          $display("FAIL rot_resp s=%0d got=%b/%h exp=%b/%h", s, m_readdatavalid, m_readdata, e.v, e.d);
        else pass_cnt++;
        last_d = e.d;
      end else begin
        if (m_readdatavalid !== 3'b000 || m_readdata !== last_d)
          $display("FAIL rot_idle s=%0d got=%b/%h exp=000/%h", s, m_readdatavalid, m_readdata, last_d);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_withdrawal();
    logic [2:0] rd [7] = '{3'b100, 3'b101, 3'b000, 3'b111, 3'b101, 3'b001, 3'b000};
    logic [2:0] wt [7] = '{3'b000, 3'b100, 3'b000, 3'b101, 3'b001, 3'b000, 3'b000};
    exp_t e;
    m_address = 3'b001;
    for (int s = 0; s < 7; s++) begin
      m_read = rd[s];
      if ($countones(rd[s]) >= 2) exp_busy++;
      #1;
      total_cnt++;
      if (m_waitrequest !== wt[s])
        $display("FAIL wd_wait s=%0d got=%b exp=%b", s, m_waitrequest, wt[s]);
      else pass_cnt++;
      if ((rd[s] & ~wt[s]) != 3'b000) sb.push_back(mk_exp(rd[s] & ~wt[s], m_address));
      @(posedge clock);
      #1;
      total_cnt++;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (m_readdatavalid !== e.v || m_readdata !== e.d)
          $display("FAIL wd_resp s=%0d got=%b/%h exp=%b/%h", s, m_readdatavalid, m_readdata, e.v, e.d);
        else pass_cnt++;
        last_d = e.d;
      end else begin
        if (m_readdatavalid !== 3'b000 || m_readdata !== last_d)
          $display("FAIL wd_idle s=%0d got=%b/%h exp=000/%h", s, m_readdatavalid, m_readdata, last_d);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (busy_cycles !== 16'(exp_busy))
      $display("FAIL wd_busy got=%0d exp=%0d", busy_cycles, exp_busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_read();
    m_read = 3'b010;
    m_address = 3'b010;
    #1;
    total_cnt++;
    if (m_waitrequest !== 3'b000)
      $display("FAIL mid_accept got=%b exp=000", m_waitrequest);
    else pass_cnt++;
    #2;
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if (m_waitrequest !== 3'b010)
      $display("FAIL mid_wait got=%b exp=010", m_waitrequest);
    else pass_cnt++;
    for (int c = 0; c < 2; c++) begin
      @(posedge clock);
      #1;
      total_cnt++;
      if (m_readdatavalid !== 3'b000 || m_readdata !== 32'd0 || busy_cycles !== 16'd0)
        $display("FAIL mid_cancel c=%0d got=%b/%h/%0d exp=000/0/0", c, m_readdatavalid, m_readdata, busy_cycles);
      else pass_cnt++;
    end
    m_read = 3'b000;
    reset_n = 1'b1;
    sb.delete();
    exp_busy = 0;
    last_d = '0;
  endtask

  task automatic test_busy_saturate();
    m_read = 3'b011;
    m_address = 3'b000;
    repeat (65534) @(posedge clock);
    #1;
    total_cnt++;
    if (busy_cycles !== 16'hFFFE)
      $display("FAIL sat_pre got=%h exp=fffe", busy_cycles);
    else pass_cnt++;
    repeat (6) @(posedge clock);
    #1;
    total_cnt++;
    if (busy_cycles !== 16'hFFFF)
      $display("FAIL sat_hold got=%h exp=ffff", busy_cycles);
    else pass_cnt++;
    m_read = 3'b000;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_rotation();
    test_withdrawal();
    test_reset_mid_read();
    test_busy_saturate();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
